// File: rtl/tlast_framer_pkg.sv
// Shared definitions for the TLAST/TUSER framer: register offsets, AXI-lite
// response codes and the per-beat tag carried through the output stage.
package tlast_framer_pkg;

  localparam logic [1:0] ADDR_PERIOD    = 2'd0;
  localparam logic [1:0] ADDR_SUBPERIOD = 2'd1;
  localparam logic [1:0] ADDR_FCNT      = 2'd2;
  localparam logic [1:0] ADDR_CTRL      = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic last;
    logic sub;
  } beat_tag_t;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry registered skid buffer: ready depends only on occupancy, output
// comes straight from the head register.
module axis_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b10:   begin tail_d = in_data; count_d = 2'd2; end
          2'b11:   begin head_d = in_data; count_d = 2'd1; end
          2'b01:   begin count_d = 2'd0; end
          default: begin count_d = 2'd1; end
        endcase
      end
      // Full: no push is possible, so only a pop can move the tail forward.
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd2;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/tlast_framer.sv
// Frames an untagged AXI-Stream: TLAST every PERIOD beats, TUSER every SUBPERIOD
// beats within a frame, software force-close and a completed-frame counter.
module tlast_framer
  import tlast_framer_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int PERIOD_BITS            = 16,
  parameter int PERIOD_INIT            = 16,
  parameter int SUBPERIOD_INIT         = 0,
  parameter int PERIOD_INIT_UPON_RESET = 0,
  parameter int FCNT_BITS              = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  s_axilite_AWVALID,
  output logic                  s_axilite_AWREADY,
  input  logic [3:0]            s_axilite_AWADDR,
  input  logic                  s_axilite_WVALID,
  output logic                  s_axilite_WREADY,
  input  logic [31:0]           s_axilite_WDATA,
  output logic                  s_axilite_BVALID,
  input  logic                  s_axilite_BREADY,
  output logic [1:0]            s_axilite_BRESP,
  input  logic                  s_axilite_ARVALID,
  output logic                  s_axilite_ARREADY,
  input  logic [3:0]            s_axilite_ARADDR,
  output logic                  s_axilite_RVALID,
  input  logic                  s_axilite_RREADY,
  output logic [31:0]           s_axilite_RDATA,
  output logic [1:0]            s_axilite_RRESP,
  input  logic [DATA_WIDTH-1:0] src_TDATA,
  input  logic                  src_TVALID,
  output logic                  src_TREADY,
  output logic [DATA_WIDTH-1:0] dst_TDATA,
  output logic                  dst_TVALID,
  input  logic                  dst_TREADY,
  output logic                  dst_TLAST,
  output logic                  dst_TUSER
);

  localparam logic [PERIOD_BITS-1:0] CNT_ZERO   = PERIOD_BITS'(0);
  localparam logic [PERIOD_BITS-1:0] CNT_ONE    = PERIOD_BITS'(1);
  localparam logic [PERIOD_BITS-1:0] PERIOD_RST = PERIOD_BITS'(PERIOD_INIT);
  localparam logic [PERIOD_BITS-1:0] SUB_RST    = PERIOD_BITS'(SUBPERIOD_INIT);
  localparam logic [FCNT_BITS-1:0]   FCNT_ONE   = FCNT_BITS'(1);
  localparam int                     SKID_W     = DATA_WIDTH + $bits(beat_tag_t);

  logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [1:0]             aw_sel_q, aw_sel_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [PERIOD_BITS-1:0] period_q, period_d, subperiod_q, subperiod_d;
  logic [FCNT_BITS-1:0]   fcnt_q, fcnt_d;
  logic                   force_q, force_d, clean_q, clean_d;
  logic [PERIOD_BITS-1:0] beat_cnt_q, beat_cnt_d, sub_cnt_q, sub_cnt_d;
  logic [PERIOD_BITS-1:0] act_p_q, act_p_d, act_s_q, act_s_d;

  logic                   aw_hs, w_hs, ar_hs, wr_fire, force_set, accept;
  logic [PERIOD_BITS-1:0] eff_p, eff_s;
  logic [31:0]            rd_mux;
  beat_tag_t              in_tag, out_tag;
  logic                   skid_in_ready;
  logic                   unused_bits;

  assign s_axilite_AWREADY = !aw_done_q && !bvalid_q;
  assign s_axilite_WREADY  = !w_done_q && !bvalid_q;
  assign s_axilite_BVALID  = bvalid_q;
  assign s_axilite_BRESP   = bresp_q;
  assign s_axilite_ARREADY = !rvalid_q;
  assign s_axilite_RVALID  = rvalid_q;
  assign s_axilite_RDATA   = rdata_q;
  assign s_axilite_RRESP   = RESP_OKAY;

  assign aw_hs   = s_axilite_AWVALID && s_axilite_AWREADY;
  assign w_hs    = s_axilite_WVALID && s_axilite_WREADY;
  assign ar_hs   = s_axilite_ARVALID && s_axilite_ARREADY;
  assign wr_fire = aw_done_q && w_done_q;

  assign unused_bits = ^{s_axilite_AWADDR[1:0], s_axilite_ARADDR[1:0], wdata_q};

  always_comb begin
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_sel_d    = aw_sel_q;
    wdata_d     = wdata_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    period_d    = period_q;
    subperiod_d = subperiod_q;
    force_set   = 1'b0;
    if (wr_fire) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      case (aw_sel_q)
        ADDR_PERIOD:    period_d    = wdata_q[PERIOD_BITS-1:0];
        ADDR_SUBPERIOD: subperiod_d = wdata_q[PERIOD_BITS-1:0];
        ADDR_FCNT:      bresp_d     = RESP_SLVERR;
        ADDR_CTRL:      force_set   = wdata_q[0];
        default:        bresp_d     = RESP_SLVERR;
      endcase
    end else begin
      if (aw_hs) begin
        aw_done_d = 1'b1;
        aw_sel_d  = s_axilite_AWADDR[3:2];
      end else begin
        aw_done_d = aw_done_q;
      end
      if (w_hs) begin
        w_done_d = 1'b1;
        wdata_d  = s_axilite_WDATA;
      end else begin
        w_done_d = w_done_q;
      end
      if (bvalid_q && s_axilite_BREADY) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
  end

  always_comb begin
    case (s_axilite_ARADDR[3:2])
      ADDR_PERIOD:    rd_mux = 32'(period_q);
      ADDR_SUBPERIOD: rd_mux = 32'(subperiod_q);
      ADDR_FCNT:      rd_mux = 32'(fcnt_q);
      ADDR_CTRL:      rd_mux = 32'd0;
      default:        rd_mux = 32'd0;
    endcase
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_axilite_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // A clean frame uses the live registers so the first beat's tags match what gets latched.
  assign accept      = src_TVALID && skid_in_ready;
  assign eff_p       = clean_q ? period_q : act_p_q;
  assign eff_s       = clean_q ? subperiod_q : act_s_q;
  assign in_tag.last = force_q || ((eff_p != CNT_ZERO) && (beat_cnt_q == (eff_p - CNT_ONE)));
  assign in_tag.sub  = in_tag.last || ((eff_s != CNT_ZERO) && (sub_cnt_q == (eff_s - CNT_ONE)));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    sub_cnt_d  = sub_cnt_q;
    clean_d    = clean_q;
    act_p_d    = act_p_q;
    act_s_d    = act_s_q;
    if (accept) begin
      if (clean_q) begin
        act_p_d = period_q;
        act_s_d = subperiod_q;
      end else begin
        act_p_d = act_p_q;
        act_s_d = act_s_q;
      end
      if (in_tag.last) begin
        beat_cnt_d = CNT_ZERO;
        sub_cnt_d  = CNT_ZERO;
        clean_d    = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_ONE;
        clean_d    = 1'b0;
        if (in_tag.sub) begin
          sub_cnt_d = CNT_ZERO;
        end else begin
          sub_cnt_d = sub_cnt_q + CNT_ONE;
        end
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    if (force_set) begin
      force_d = 1'b1;
    end else if (accept && in_tag.last) begin
      force_d = 1'b0;
    end else begin
      force_d = force_q;
    end
    if (dst_TVALID && dst_TREADY && dst_TLAST) begin
      fcnt_d = fcnt_q + FCNT_ONE;
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_sel_q   <= 2'd0;
      wdata_q    <= 32'd0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      fcnt_q     <= FCNT_BITS'(0);
      force_q    <= 1'b0;
      clean_q    <= 1'b1;
      beat_cnt_q <= CNT_ZERO;
      sub_cnt_q  <= CNT_ZERO;
      act_p_q    <= CNT_ZERO;
      act_s_q    <= CNT_ZERO;
    end else begin
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_sel_q   <= aw_sel_d;
      wdata_q    <= wdata_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      fcnt_q     <= fcnt_d;
      force_q    <= force_d;
      clean_q    <= clean_d;
      beat_cnt_q <= beat_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      act_p_q    <= act_p_d;
      act_s_q    <= act_s_d;
    end
  end

  // Configuration survives reset unless the instance asks for init values to be restored.
  always_ff @(posedge ap_clk) begin
    if (ap_rst && (PERIOD_INIT_UPON_RESET != 0)) begin
      period_q    <= PERIOD_RST;
      subperiod_q <= SUB_RST;
    end else if (ap_rst) begin
      period_q    <= period_q;
      subperiod_q <= subperiod_q;
    end else begin
      period_q    <= period_d;
      subperiod_q <= subperiod_d;
    end
  end

  axis_skid2 #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .in_data   ({src_TDATA, in_tag}),
    .in_valid  (src_TVALID),
    .in_ready  (skid_in_ready),
    .out_data  ({dst_TDATA, out_tag}),
    .out_valid (dst_TVALID),
    .out_ready (dst_TREADY)
  );

  assign src_TREADY = skid_in_ready;
  assign dst_TLAST  = out_tag.last;
  assign dst_TUSER  = out_tag.sub;

endmodule

// File: tb/tb_tlast_framer.sv
// Scoreboard bench for tlast_framer: the driver queues hand-computed {data,last,sub}
// per accepted beat, a negedge monitor pops and compares every output handshake.
module tb_tlast_framer;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [3:0]  awaddr = 4'd0, araddr = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  src_data = 8'd0;
  logic        src_valid = 1'b0, src_ready;
  logic [7:0]  dst_data;
  logic        dst_valid, dst_last, dst_user, dst_ready;
  logic        rdy_cmd = 1'b1, tog_en = 1'b0, tog_q = 1'b0;

  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_src_ready;
  logic [1:0]  b_bresp, b_rresp;
  logic [31:0] b_rdata;
  logic [7:0]  b_dst_data;
  logic        b_dst_valid, b_dst_last, b_dst_user;
  logic        unused_b;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       sub;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   occ = 0;
  int   b_count = 0;

  assign dst_ready = tog_en ? tog_q : rdy_cmd;
  assign unused_b  = ^{b_awready, b_wready, b_bvalid, b_arready, b_rvalid, b_src_ready,
                       b_bresp, b_rresp, b_dst_data, b_dst_valid, b_dst_last, b_dst_user};

  always #5 ap_clk = ~ap_clk;

  tlast_framer #(
    .DATA_WIDTH(8), .PERIOD_BITS(16), .PERIOD_INIT(16), .SUBPERIOD_INIT(0),
    .PERIOD_INIT_UPON_RESET(1), .FCNT_BITS(32)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axilite_AWVALID(awvalid), .s_axilite_AWREADY(awready), .s_axilite_AWADDR(awaddr),
    .s_axilite_WVALID(wvalid), .s_axilite_WREADY(wready), .s_axilite_WDATA(wdata),
    .s_axilite_BVALID(bvalid), .s_axilite_BREADY(bready), .s_axilite_BRESP(bresp),
    .s_axilite_ARVALID(arvalid), .s_axilite_ARREADY(arready), .s_axilite_ARADDR(araddr),
    .s_axilite_RVALID(rvalid), .s_axilite_RREADY(rready), .s_axilite_RDATA(rdata),
    .s_axilite_RRESP(rresp),
    .src_TDATA(src_data), .src_TVALID(src_valid), .src_TREADY(src_ready),
    .dst_TDATA(dst_data), .dst_TVALID(dst_valid), .dst_TREADY(dst_ready),
    .dst_TLAST(dst_last), .dst_TUSER(dst_user)
  );

  // Same stimulus, but configuration is kept across reset.
  tlast_framer #(
    .DATA_WIDTH(8), .PERIOD_BITS(16), .PERIOD_INIT(16), .SUBPERIOD_INIT(0),
    .PERIOD_INIT_UPON_RESET(0), .FCNT_BITS(32)
  ) dut_keep (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axilite_AWVALID(awvalid), .s_axilite_AWREADY(b_awready), .s_axilite_AWADDR(awaddr),
    .s_axilite_WVALID(wvalid), .s_axilite_WREADY(b_wready), .s_axilite_WDATA(wdata),
    .s_axilite_BVALID(b_bvalid), .s_axilite_BREADY(bready), .s_axilite_BRESP(b_bresp),
    .s_axilite_ARVALID(arvalid), .s_axilite_ARREADY(b_arready), .s_axilite_ARADDR(araddr),
    .s_axilite_RVALID(b_rvalid), .s_axilite_RREADY(rready), .s_axilite_RDATA(b_rdata),
    .s_axilite_RRESP(b_rresp),
    .src_TDATA(src_data), .src_TVALID(src_valid), .src_TREADY(b_src_ready),
    .dst_TDATA(b_dst_data), .dst_TVALID(b_dst_valid), .dst_TREADY(dst_ready),
    .dst_TLAST(b_dst_last), .dst_TUSER(b_dst_user)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge ap_clk) if (tog_en) #1 tog_q = ~tog_q;

  // Monitor: scoreboard pops, skid occupancy model, B handshake count.
  always @(negedge ap_clk) begin
    exp_t e;
    int   push, pop;
    if (ap_rst) begin
      exp_q.delete();
      occ = 0;
    end else begin
      check("src_tready_vs_occupancy", {31'd0, src_ready}, {31'd0, occ != 2});
      push = (src_valid && src_ready) ? 1 : 0;
      pop  = (dst_valid && dst_ready) ? 1 : 0;
      if (pop == 1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'd0, dst_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("dst_data", {24'd0, dst_data}, {24'd0, e.data});
          check("dst_tlast", {31'd0, dst_last}, {31'd0, e.last});
          check("dst_tuser", {31'd0, dst_user}, {31'd0, e.sub});
        end
      end
      occ = occ + push - pop;
      if (bvalid && bready) b_count++;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic s);
    int n = 0;
    logic ok;
    src_valid = 1'b1;
    src_data  = d;
    do begin
      @(negedge ap_clk);
      ok = src_ready;
      if (ok) exp_q.push_back('{data: d, last: l, sub: s});
      @(posedge ap_clk); #1;
      n++;
    end while (!ok && n < 200);
    src_valid = 1'b0;
    if (!ok) check("src_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] base, input int cnt,
                            input logic [31:0] last_m, input logic [31:0] sub_m);
    for (int i = 0; i < cnt; i++) send_beat(base + 8'(i), last_m[i], sub_m[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge ap_clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    @(posedge ap_clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input int w_lag, output logic [1:0] resp);
    logic aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs;
    int   n = 0;
    awvalid = 1'b1; awaddr = addr; wdata = data; wvalid = (w_lag == 0);
    while ((aw_pend || w_pend) && n < 50) begin
      @(negedge ap_clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge ap_clk); #1;
      n++;
      if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin wvalid = 1'b0;  w_pend = 1'b0;  end
      if (w_pend && n >= w_lag) wvalid = 1'b1;
    end
    check("wr_aw_w_accepted", {30'd0, aw_pend, w_pend}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!bvalid && n < 50);
    check("wr_bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge ap_clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] da, output logic [31:0] db);
    int n = 0;
    arvalid = 1'b1; araddr = addr;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!arready && n < 50);
    @(posedge ap_clk); #1;
    arvalid = 1'b0; rready = 1'b1; n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!rvalid && n < 50);
    check("rd_rvalid_seen", {31'd0, rvalid}, 32'd1);
    da = rdata;
    db = b_rdata;
    @(posedge ap_clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] ra, rb;
    int          bc;

    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rst_awready", {31'd0, awready}, 32'd1);
    check("rst_wready", {31'd0, wready}, 32'd1);
    check("rst_arready", {31'd0, arready}, 32'd1);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_dst_tvalid", {31'd0, dst_valid}, 32'd0);
    check("rst_src_tready", {31'd0, src_ready}, 32'd1);
    @(posedge ap_clk); #1;
    axi_read(4'h0, ra, rb);  check("rst_period_init", ra, 32'd16);
    axi_read(4'h8, ra, rb);  check("rst_fcnt", ra, 32'd0);

    // PERIOD=4, SUBPERIOD=2, 12 back-to-back beats
    axi_write(4'h0, 32'd4, 0, resp);  check("wr_period_okay", {30'd0, resp}, 32'd0);
    axi_write(4'h4, 32'd2, 0, resp);  check("wr_sub_okay", {30'd0, resp}, 32'd0);
    send_frame(8'd0, 12, 32'b1000_1000_1000, 32'b1010_1010_1010);
    wait_drain();
    axi_read(4'h8, ra, rb);  check("fcnt_after_12", ra, 32'd3);

    // PERIOD 4 -> 3 mid-frame: current frame keeps 4, next one uses 3
    send_frame(8'd16, 2, 32'b00, 32'b10);
    axi_write(4'h0, 32'h0001_0003, 0, resp);
    axi_read(4'h0, ra, rb);  check("period_readback_3", ra, 32'd3);
    send_frame(8'd18, 5, 32'b10010, 32'b11010);
    wait_drain();
    axi_read(4'h8, ra, rb);  check("fcnt_after_shrink", ra, 32'd5);

    // force-close mid-frame (issued twice), full frame of 8, then force while clean
    axi_write(4'h0, 32'd8, 0, resp);
    axi_write(4'h4, 32'd0, 0, resp);
    send_frame(8'd32, 2, 32'b00, 32'b00);
    axi_write(4'hC, 32'd1, 0, resp);
    axi_write(4'hC, 32'd1, 0, resp);
    send_beat(8'd34, 1'b1, 1'b1);
    send_frame(8'd35, 8, 32'b1000_0000, 32'b1000_0000);
    axi_write(4'hC, 32'd1, 0, resp);
    axi_read(4'hC, ra, rb);  check("ctrl_reads_zero", ra, 32'd0);
    send_beat(8'd43, 1'b1, 1'b1);
    wait_drain();
    axi_read(4'h8, ra, rb);  check("fcnt_after_force", ra, 32'd8);

    // FCNT is read-only; AW leads W by 3 cycles
    bc = b_count;
    axi_write(4'h8, 32'h55, 3, resp);  check("fcnt_write_slverr", {30'd0, resp}, 32'd2);
    repeat (3) @(posedge ap_clk);
    #1 check("single_b_response", b_count - bc, 32'd1);
    check("bvalid_low_after_b", {31'd0, bvalid}, 32'd0);
    axi_read(4'h8, ra, rb);  check("fcnt_unchanged", ra, 32'd8);
    axi_write(4'h0, 32'd5, 3, resp);  check("lagged_write_okay", {30'd0, resp}, 32'd0);
    axi_read(4'h0, ra, rb);  check("period_readback_5", ra, 32'd5);

    // dst_TREADY toggling, random source gaps, 100 beats with PERIOD=5
    tog_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2) == 0 ? 1 : 0) @(posedge ap_clk);
      #0 send_beat(8'(64 + i), (i % 5) == 4, (i % 5) == 4);
    end
    tog_en = 1'b0;
    rdy_cmd = 1'b1;
    wait_drain();
    axi_read(4'h8, ra, rb);  check("fcnt_after_random", ra, 32'd28);

    // reset mid-frame with two beats stuck in the skid buffer
    rdy_cmd = 1'b0;
    send_frame(8'd200, 2, 32'b00, 32'b00);
    @(negedge ap_clk);
    check("full_src_tready_low", {31'd0, src_ready}, 32'd0);
    @(posedge ap_clk); #1 ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("midrst_dst_idle", {31'd0, dst_valid}, 32'd0);
    check("midrst_src_tready", {31'd0, src_ready}, 32'd1);
    check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
    @(posedge ap_clk); #1;
    axi_read(4'h0, ra, rb);
    check("midrst_period_restored", ra, 32'd16);
    check("midrst_period_kept", rb, 32'd5);
    axi_read(4'h8, ra, rb);  check("midrst_fcnt_zero", ra, 32'd0);
    rdy_cmd = 1'b1;
    send_frame(8'd100, 16, 32'h0000_8000, 32'h0000_8000);
    wait_drain();
    axi_read(4'h8, ra, rb);  check("fcnt_after_rst_frame", ra, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
